// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush controller for the 5-stage pipeline. It combines the
//   decode/execute register fields, the cache ready strobes, EX branch
//   resolution and the MEM_WB halt bit. From these it produces the
//   enable/stall/flush controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
//   A small FSM (RUN / DWAIT / HALT) tracks data-memory waits and the halt
//   condition. A sticky timeout error is raised when a data-memory wait
//   lasts too long.
//
// Configuration macro:
//   HAZARD_PERF_CNT_EN  adds the saturating perf counters stall_cycles and
//                       flush_count (PERF_W bits each).
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   ifid_rs, ifid_rt    source registers of the instruction in IF_ID
//   idex_rt             load destination of the instruction in ID_EX
//   idex_memread        ID_EX instruction is a load
//   exmem_req           EX_MEM issues a data-memory request
//   dhit, ihit          data / instruction cache ready
//   ex_mispredict       EX resolved a branch against its prediction
//   wb_halt             halt bit at the MEM_WB output
//   pc_en, ifid_en, ifid_flush, idex_en, idex_stall, idex_flush,
//   exmem_en, memwb_en  pipeline register controls (combinational)
//   halt                registered, sticky CPU halt
//   err_timeout         registered, sticky data-wait timeout
//   stall_cycles, flush_count   perf counters (HAZARD_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_W     = 5,
  parameter int DWAIT_MAX = 64,
  parameter int PERF_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             idex_memread,
  input  logic             exmem_req,
  input  logic             dhit,
  input  logic             ihit,
  input  logic             ex_mispredict,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             halt,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count,
`endif
  output logic             err_timeout
);

  localparam int CNT_W = $clog2(DWAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ERR = CNT_W'(DWAIT_MAX - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] dwait_cnt;
  logic [CNT_W-1:0] dwait_cnt_inc;
  logic             freeze;
  logic             load_use;
  logic             rule_mispredict;

  assign freeze   = exmem_req & ~dhit;
  assign load_use = idex_memread & (idex_rt != '0) &
                    ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  // Saturating increment of the wait counter.
  assign dwait_cnt_inc = (dwait_cnt == CNT_MAX) ? dwait_cnt : dwait_cnt + 1'b1;

  // ---- control FSM: state, halt, wait counter, timeout ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_RUN;
      halt        <= 1'b0;
      err_timeout <= 1'b0;
      dwait_cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          // A halt arriving together with a freeze wins.
          if (wb_halt) begin
            state <= ST_HALT;
            halt  <= 1'b1;
          end else if (freeze) begin
            state <= ST_DWAIT;
          end
        end
        ST_DWAIT: begin
          if (dhit && !wb_halt) begin
            state     <= ST_RUN;
            dwait_cnt <= '0;
          end else begin
            dwait_cnt <= dwait_cnt_inc;
            if (dwait_cnt_inc >= CNT_ERR) err_timeout <= 1'b1;
            if (wb_halt) begin
              state <= ST_HALT;
              halt  <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          // Only reset leaves HALT.
          state <= ST_HALT;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // ---- combinational hazard response, first matching rule wins ----
  always_comb begin
    pc_en           = 1'b0;
    ifid_en         = 1'b0;
    ifid_flush      = 1'b0;
    idex_en         = 1'b0;
    idex_stall      = 1'b0;
    idex_flush      = 1'b0;
    exmem_en        = 1'b0;
    memwb_en        = 1'b0;
    rule_mispredict = 1'b0;
    if (RST || state == ST_HALT || freeze) begin
      // Whole pipe holds; a pending mispredict is serviced once dhit arrives.
    end else if (ex_mispredict) begin
      rule_mispredict = 1'b1;
      pc_en           = 1'b1;
      ifid_flush      = 1'b1;
      idex_flush      = 1'b1;
      exmem_en        = 1'b1;
      memwb_en        = 1'b1;
    end else if (load_use) begin
      // One bubble: the bubble clears idex_memread so this cannot repeat.
      idex_en    = 1'b1;
      idex_stall = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else if (!ihit) begin
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (state != ST_HALT && !pc_en && stall_cycles != PERF_MAX)
        stall_cycles <= stall_cycles + 1'b1;
      if (rule_mispredict && flush_count != PERF_MAX)
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the control rules.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int DW    = 8;
  localparam int PW    = 6;
  localparam int PMAX  = (1 << PW) - 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic [REG_W-1:0] ifid_rs, ifid_rt, idex_rt;
  logic             idex_memread, exmem_req, dhit, ihit, ex_mispredict, wb_halt;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_stall, idex_flush;
  logic             exmem_en, memwb_en, halt, err_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [PW-1:0]    stall_cycles, flush_count;
`endif

  pipeline_hazard_ctrl #(.REG_W(REG_W), .DWAIT_MAX(DW), .PERF_W(PW)) dut (
    .CLK(CLK), .RST(RST),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rt(idex_rt),
    .idex_memread(idex_memread), .exmem_req(exmem_req), .dhit(dhit), .ihit(ihit),
    .ex_mispredict(ex_mispredict), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .halt(halt),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_stall, idex_flush, exmem_en, memwb_en}
  wire [7:0] outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_stall, idex_flush,
                     exmem_en, memwb_en};

  int total = 0;
  int bad   = 0;

  // Model state
  bit m_halt, m_wait, m_err;
  int m_cnt, m_stall, m_flush;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit mis_fires();
    return !RST && !m_halt && !(exmem_req && !dhit) && ex_mispredict;
  endfunction

  function automatic logic [7:0] expect_outs();
    bit frz = exmem_req && !dhit;
    bit lu  = idex_memread && (idex_rt != 0) &&
              ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    if (RST || m_halt || frz) return 8'b0000_0000;
    if (ex_mispredict)        return 8'b1010_0111;
    if (lu)                   return 8'b0001_1011;
    if (!ihit)                return 8'b0011_0011;
    return 8'b1101_0011;
  endfunction

  task automatic model_reset();
    m_halt = 0; m_wait = 0; m_err = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
  endtask

  // Compare everything the DUT currently shows against the model.
  task automatic check_now(input string tag);
    #1;
    chk({tag, "_outs"}, outs, expect_outs());
    chk({tag, "_halt"}, halt, m_halt);
    chk({tag, "_err"}, err_timeout, m_err);
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "_stallc"}, stall_cycles, m_stall);
    chk({tag, "_flushc"}, flush_count, m_flush);
`endif
  endtask

  // Apply the clock edge to the model, then move to the next negedge.
  task automatic advance();
    logic [7:0] e;
    e = expect_outs();
    if (!m_halt) begin
      if (!e[7] && m_stall < PMAX) m_stall++;
      if (mis_fires() && m_flush < PMAX) m_flush++;
      if (m_wait) begin
        if (dhit && !wb_halt) begin
          m_wait = 0;
          m_cnt  = 0;
        end else begin
          if (m_cnt < DW) m_cnt++;
          if (m_cnt >= DW - 1) m_err = 1;
        end
      end else if (exmem_req && !dhit && !wb_halt) begin
        m_wait = 1;
      end
      if (wb_halt) begin
        m_halt = 1;
        m_wait = 0;
      end
    end
    @(negedge CLK);
  endtask

  task automatic step(input string tag);
    check_now(tag);
    advance();
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b1;
    model_reset();
    check_now(tag);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic idle_inputs();
    ifid_rs = 5'd1; ifid_rt = 5'd3; idex_rt = 5'd0;
    idex_memread = 0; exmem_req = 0; dhit = 1; ihit = 1; ex_mispredict = 0; wb_halt = 0;
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge CLK);
    check_now("reset");
    chk("reset_outs_zero", outs, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    step("idle");

    // 1: load-use on rs -> single bubble
    idex_memread = 1; idex_rt = 5'd2; ifid_rs = 5'd2;
    check_now("lu");
    chk("lu_pc", pc_en, 1'b0);
    chk("lu_stall", idex_stall, 1'b1);
    advance();
    idex_memread = 0;
    check_now("lu_after");
    chk("lu_after_en", outs, 8'b1101_0011);
    advance();

    // 2: load-use with rt=0 -> no stall
    idex_memread = 1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    check_now("lu_r0");
    chk("lu_r0_en", outs, 8'b1101_0011);
    advance();
    idle_inputs();

    // 3: 5-cycle data wait, then hit
    exmem_req = 1; dhit = 0;
    for (int i = 0; i < 5; i++) begin
      check_now("dwait");
      chk("dwait_zero", outs, 8'h00);
      advance();
    end
    dhit = 1;
    check_now("dwait_hit");
    chk("dwait_hit_en", outs, 8'b1101_0011);
    advance();
    exmem_req = 0;
    step("dwait_run");

    // 4: mispredict held during a 3-cycle wait
    exmem_req = 1; dhit = 0; ex_mispredict = 1;
    for (int i = 0; i < 3; i++) begin
      check_now("mis_frz");
      chk("mis_frz_noflush", {ifid_flush, idex_flush}, 2'b00);
      advance();
    end
    dhit = 1;
    check_now("mis_hit");
    chk("mis_hit_flush", {ifid_flush, idex_flush}, 2'b11);
    advance();
    idle_inputs();

    // 5: timeout, sticky, cleared by reset
    exmem_req = 1; dhit = 0;
    for (int i = 0; i < DW + 3; i++) step("tmo");
    chk("tmo_set", err_timeout, 1'b1);
    dhit = 1; exmem_req = 0;
    step("tmo_sticky");
    step("tmo_sticky2");
    do_reset("tmo_rst");

    // 6: halt one edge after wb_halt, wins over freeze, async reset clears
    step("pre_halt");
    wb_halt = 1; exmem_req = 1; dhit = 0;
    check_now("halt_in");
    chk("halt_not_yet", halt, 1'b0);
    advance();
    wb_halt = 0; exmem_req = 0; dhit = 1;
    for (int i = 0; i < 3; i++) begin
      check_now("halted");
      chk("halted_flags", {halt, outs}, 9'h100);
      advance();
    end
    do_reset("halt_rst");

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      ifid_rs       = REG_W'($urandom_range(0, 3));
      ifid_rt       = REG_W'($urandom_range(0, 3));
      idex_rt       = REG_W'($urandom_range(0, 3));
      idex_memread  = 1'($urandom_range(0, 1));
      exmem_req     = ($urandom_range(0, 2) == 0);
      dhit          = ((i % 500) < 40) ? ($urandom_range(0, 24) == 0)
                                        : ($urandom_range(0, 3) != 0);
      ihit          = ($urandom_range(0, 5) != 0);
      ex_mispredict = ($urandom_range(0, 6) == 0);
      wb_halt       = ($urandom_range(0, 299) == 0);
      if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0)
        do_reset("rnd_rst");
      else
        step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
